// File: rtl/csr_access_ctrl.sv
// CSR read-modify-write requester for the custom counter bank; one op in flight; respValid 3 cycles after accept (4 with write, 1 if illegal).
// Backpressure: reqReady only in IDLE; RESP outputs hold stable until respReady.
module csr_access_ctrl #(
    parameter logic [11:0] CSR_BASE = 12'h7C0,
    parameter int          NUM_CSR  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [1:0]  reqOp,
    input  logic        reqImm,
    input  logic [4:0]  reqZimm,
    input  logic [31:0] reqRs1,
    input  logic [11:0] reqAddr,
    output logic [4:0]  rAddr,
    output logic        rEn,
    input  logic [31:0] csr,
    output logic        wEn,
    output logic [4:0]  wAddr,
    output logic [31:0] wData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respIllegal
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic [2:0]  state;
    logic [1:0]  opReg;
    logic [31:0] operand;
    logic [31:0] oldVal;
    logic [31:0] newVal;
    logic [4:0]  index;
    logic        illegal;

    logic [11:0] addrDiff;
    logic        inRange;
    logic [31:0] reqOperand;
    logic [31:0] modVal;
    logic        needWrite;

    // Addresses below CSR_BASE wrap to large differences and fail the range check.
    assign addrDiff   = reqAddr - CSR_BASE;
    assign inRange    = addrDiff < 12'(NUM_CSR);
    assign reqOperand = reqImm ? {27'd0, reqZimm} : reqRs1;

    always_comb begin
        modVal = operand;
        case (opReg)
            OP_RS:   modVal = csr | operand;
            OP_RC:   modVal = csr & ~operand;
            default: modVal = operand;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not touch the bank.
    assign needWrite = (opReg == OP_RW) || (operand != 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            opReg   <= 2'b00;
            operand <= 32'd0;
            oldVal  <= 32'd0;
            newVal  <= 32'd0;
            index   <= 5'd0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        opReg   <= reqOp;
                        operand <= reqOperand;
                        index   <= addrDiff[4:0];
                        if (!inRange || reqOp == 2'b00) begin
                            illegal <= 1'b1;
                            oldVal  <= 32'd0;
                            state   <= RESP;
                        end else begin
                            illegal <= 1'b0;
                            state   <= READ;
                        end
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    oldVal <= csr;
                    newVal <= modVal;
                    state  <= needWrite ? WRITE : RESP;
                end
                WRITE: state <= RESP;
                RESP: begin
                    if (respReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reqReady    = (state == IDLE);
    assign rEn         = (state == READ);
    assign rAddr       = index;
    assign wEn         = (state == WRITE);
    assign wAddr       = index;
    assign wData       = newVal;
    assign respValid   = (state == RESP);
    assign respData    = oldVal;
    assign respIllegal = (state == RESP) && illegal;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: bank memory model, per-cycle compare against a behavioural
// model of each CSR op, plus literal expectations for data, latency and write counts.
module tb_csr_access_ctrl;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [1:0]  reqOp;
    logic        reqImm;
    logic [4:0]  reqZimm;
    logic [31:0] reqRs1;
    logic [11:0] reqAddr;
    logic [4:0]  rAddr;
    logic        rEn;
    logic [31:0] csr;
    logic        wEn;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respIllegal;

    csr_access_ctrl #(.CSR_BASE(12'h7C0), .NUM_CSR(8)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqImm(reqImm),
        .reqZimm(reqZimm), .reqRs1(reqRs1), .reqAddr(reqAddr),
        .rAddr(rAddr), .rEn(rEn), .csr(csr),
        .wEn(wEn), .wAddr(wAddr), .wData(wData),
        .respValid(respValid), .respReady(respReady), .respData(respData),
        .respIllegal(respIllegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank memory seen by the DUT; preload port is only driven while the DUT is idle.
    logic [31:0] bankMem [0:31];
    logic        preEn;
    logic [4:0]  preIdx;
    logic [31:0] preVal;

    always @(posedge clk) begin
        if (preEn) bankMem[preIdx] <= preVal;
        if (wEn) bankMem[wAddr] <= wData;
        csr <= rEn ? bankMem[rAddr] : 32'hDEAD_BEEF;
    end

    // Model state and expectations for the op in flight.
    logic [31:0] modelBank [0:7];
    logic        expIll;
    logic [31:0] expData;
    logic [4:0]  expIdx;
    logic [31:0] expWData;
    logic        expWrite;
    logic        busy;

    int          checks;
    int          errors;
    int          wCount;
    int          rCount;
    int          wStart;
    int          rStart;
    logic [31:0] lastWData;

    logic        endCheck;
    logic        chkResp;
    int          measLat;
    logic        gotValid;
    logic [31:0] lastData;
    logic        lastIll;
    int          ckLat;
    logic [31:0] ckData;
    logic        ckIll;
    int          ckWrites;
    int          ckReads;
    logic [31:0] ckWData;

    logic        prevValid;
    logic        prevReady;
    logic [31:0] prevData;
    logic        prevIll;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst reqReady", 32'(reqReady), 32'd1);
            chk("rst rEn", 32'(rEn), 32'd0);
            chk("rst wEn", 32'(wEn), 32'd0);
            chk("rst respValid", 32'(respValid), 32'd0);
            chk("rst respIllegal", 32'(respIllegal), 32'd0);
            chk("rst rAddr", 32'(rAddr), 32'd0);
            chk("rst wAddr", 32'(wAddr), 32'd0);
            chk("rst wData", wData, 32'd0);
            chk("rst respData", respData, 32'd0);
            prevValid = 1'b0;
        end else begin
            chk("reqReady vs busy", 32'(reqReady), 32'(!busy));
            if (rEn && wEn) chk("rEn wEn exclusive", 32'd1, 32'd0);
            if (rEn) begin
                rCount++;
                chk("rEn on legal op", 32'(expIll), 32'd0);
                chk("rAddr", 32'(rAddr), 32'(expIdx));
            end
            if (wEn) begin
                wCount++;
                lastWData = wData;
                chk("wEn expected", 32'(expWrite), 32'd1);
                chk("wAddr", 32'(wAddr), 32'(expIdx));
                chk("wData", wData, expWData);
            end
            if (respValid) begin
                chk("respData model", respData, expData);
                chk("respIllegal model", 32'(respIllegal), 32'(expIll));
            end
            if (prevValid && !prevReady) begin
                chk("respValid held", 32'(respValid), 32'd1);
                chk("respData held", respData, prevData);
                chk("respIllegal held", 32'(respIllegal), 32'(prevIll));
            end
            if (prevValid && prevReady) chk("respValid drops", 32'(respValid), 32'd0);
            prevValid = respValid;
            prevReady = respReady;
            prevData  = respData;
            prevIll   = respIllegal;
        end
        if (endCheck) begin
            chk("wEn count", 32'(wCount - wStart), 32'(ckWrites));
            chk("rEn count", 32'(rCount - rStart), 32'(ckReads));
            if (ckWrites > 0) chk("wData literal", lastWData, ckWData);
            if (chkResp) begin
                chk("respValid seen", 32'(gotValid), 32'd1);
                chk("latency", 32'(measLat), 32'(ckLat));
                chk("respData literal", lastData, ckData);
                chk("respIllegal literal", 32'(lastIll), 32'(ckIll));
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        preEn  = 1'b1;
        preIdx = 5'(idx);
        preVal = val;
        modelBank[idx] = val;
        @(posedge clk); #1;
        preEn = 1'b0;
    endtask

    task automatic postEndCheck();
        endCheck = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        endCheck = 1'b0;
    endtask

    // Behavioural view: address window 0x7C0..0x7C7, op 00 illegal, set/clear with 0 is read-only.
    task automatic setModel(input logic [1:0] op, input logic imm, input logic [4:0] zimm,
                            input logic [31:0] rs1, input logic [11:0] addr);
        int          a;
        logic [31:0] opnd;
        logic [31:0] oldv;
        a = int'(addr);
        expIll = (op == 2'b00) || (a < 'h7C0) || (a > 'h7C7);
        expIdx = expIll ? 5'd0 : 5'(a - 'h7C0);
        opnd = imm ? 32'(zimm) : rs1;
        oldv = expIll ? 32'd0 : modelBank[expIdx];
        expData = oldv;
        if (op == 2'b01)      expWData = opnd;
        else if (op == 2'b10) expWData = oldv | opnd;
        else                  expWData = oldv & ~opnd;
        expWrite = !expIll && (op == 2'b01 || opnd != 32'd0);
        wStart = wCount;
        rStart = rCount;
    endtask

    task automatic doOp(input logic [1:0] op, input logic imm, input logic [4:0] zimm,
                        input logic [31:0] rs1, input logic [11:0] addr, input int holdN,
                        input logic [31:0] litData, input logic litIll, input int litLat,
                        input int litWrites, input logic [31:0] litWData);
        int lat;
        setModel(op, imm, zimm, rs1, addr);
        respReady = (holdN == 0);
        reqOp = op; reqImm = imm; reqZimm = zimm; reqRs1 = rs1; reqAddr = addr;
        reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        busy = 1'b1;
        lat = 1;
        while (!respValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        measLat  = lat;
        gotValid = respValid;
        lastData = respData;
        lastIll  = respIllegal;
        repeat (holdN) begin
            @(posedge clk); #1;
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0;
        if (expWrite) modelBank[expIdx] = expWData;
        chkResp = 1'b1;
        ckLat = litLat; ckData = litData; ckIll = litIll;
        ckWrites = litWrites; ckReads = litIll ? 0 : 1; ckWData = litWData;
        postEndCheck();
    endtask

    initial begin
        checks = 0; errors = 0; wCount = 0; rCount = 0; wStart = 0; rStart = 0;
        lastWData = 32'd0; endCheck = 1'b0; chkResp = 1'b0; busy = 1'b0;
        measLat = 0; gotValid = 1'b0; lastData = 32'd0; lastIll = 1'b0;
        ckLat = 0; ckData = 32'd0; ckIll = 1'b0; ckWrites = 0; ckReads = 0; ckWData = 32'd0;
        prevValid = 1'b0; prevReady = 1'b0; prevData = 32'd0; prevIll = 1'b0;
        expIll = 1'b0; expData = 32'd0; expIdx = 5'd0; expWData = 32'd0; expWrite = 1'b0;
        preEn = 1'b0; preIdx = 5'd0; preVal = 32'd0;
        for (int i = 0; i < 8; i++) modelBank[i] = 32'd0;
        rst = 1'b1; reqValid = 1'b0; reqOp = 2'b00; reqImm = 1'b0; reqZimm = 5'd0;
        reqRs1 = 32'd0; reqAddr = 12'd0; respReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) preload(i, 32'd0);
        preload(2, 32'h5);
        preload(0, 32'hF0);
        preload(1, 32'h1234);
        preload(7, 32'h100);
        preload(3, 32'h77);

        //    op     imm   zimm   rs1            addr     hold litData       ill   lat wr litWData
        doOp(2'b01, 1'b0, 5'd0,  32'hA,         12'h7C2, 0, 32'h5,        1'b0, 4, 1, 32'hA);
        doOp(2'b10, 1'b1, 5'h03, 32'hFFFF_FFFF, 12'h7C0, 0, 32'hF0,       1'b0, 4, 1, 32'hF3);
        doOp(2'b11, 1'b0, 5'd0,  32'd0,         12'h7C1, 0, 32'h1234,     1'b0, 3, 0, 32'd0);
        doOp(2'b01, 1'b0, 5'd0,  32'h55,        12'h7C8, 0, 32'd0,        1'b1, 1, 0, 32'd0);
        doOp(2'b10, 1'b0, 5'd0,  32'h55,        12'h7BF, 0, 32'd0,        1'b1, 1, 0, 32'd0);
        doOp(2'b00, 1'b0, 5'd0,  32'h55,        12'h7C0, 0, 32'd0,        1'b1, 1, 0, 32'd0);
        doOp(2'b11, 1'b0, 5'd0,  32'hF0,        12'h7C0, 0, 32'hF3,       1'b0, 4, 1, 32'h03);
        doOp(2'b10, 1'b0, 5'd0,  32'h1,         12'h7C7, 0, 32'h100,      1'b0, 4, 1, 32'h101);
        doOp(2'b01, 1'b1, 5'd0,  32'hFFFF,      12'h7C2, 0, 32'hA,        1'b0, 4, 1, 32'h0);
        doOp(2'b10, 1'b0, 5'd0,  32'd0,         12'h7C0, 5, 32'h3,        1'b0, 3, 0, 32'd0);
        doOp(2'b01, 1'b0, 5'd0,  32'h9,         12'h000, 5, 32'd0,        1'b1, 1, 0, 32'd0);

        // Reset while a write is pending: the aborted RW must leave bank[3] untouched.
        setModel(2'b01, 1'b0, 5'd0, 32'h99, 12'h7C3);
        reqOp = 2'b01; reqImm = 1'b0; reqRs1 = 32'h99; reqAddr = 12'h7C3; reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chkResp = 1'b0; ckWrites = 0; ckReads = 1;
        postEndCheck();

        doOp(2'b10, 1'b0, 5'd0,  32'd0,         12'h7C3, 0, 32'h77,       1'b0, 3, 0, 32'd0);
        doOp(2'b10, 1'b1, 5'd0,  32'd0,         12'h7C2, 0, 32'h0,        1'b0, 3, 0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
